unidade_controle: RTL

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle_pkg.sv | 48 ++++
 rtl/unidade_controle_if.sv | 13 +
 rtl/unidade_controle_avalia_condicao.sv | 26 ++
 rtl/unidade_controle.sv | 133 +++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the control unit: FSM states, instruction classes,
// instruction field positions and flag-index constants.
package unidade_controle_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } estado_t;

  typedef enum logic [1:0] {
    CL_ALU   = 2'b00,
    CL_JCOND = 2'b01,
    CL_JINC  = 2'b10,
    CL_HALT  = 2'b11
  } classe_t;

  // Instruction field positions (16-bit instruction word)
  localparam int CLASSE_MSB   = 15;
  localparam int CLASSE_LSB   = 14;
  localparam int ALU_OP_MSB   = 13;
  localparam int ALU_OP_LSB   = 9;
  localparam int ALU_SA_MSB   = 8;
  localparam int ALU_SA_LSB   = 5;
  localparam int ALU_SB_MSB   = 4;
  localparam int ALU_SB_LSB   = 1;
  localparam int ALU_HAB_BIT  = 0;
  localparam int JMP_IDX_MSB  = 13;
  localparam int JMP_IDX_LSB  = 12;
  localparam int JMP_POL_BIT  = 11;
  localparam int JMP_ALVO_MSB = 7;
  localparam int JMP_ALVO_LSB = 0;

  // Flag index encoding and the matching bit in Flags_ZCSO
  localparam logic [1:0] IDX_Z = 2'b00;
  localparam logic [1:0] IDX_C = 2'b01;
  localparam logic [1:0] IDX_S = 2'b10;
  localparam logic [1:0] IDX_O = 2'b11;

  localparam int FLAG_BIT_Z = 3;
  localparam int FLAG_BIT_C = 2;
  localparam int FLAG_BIT_S = 1;
  localparam int FLAG_BIT_O = 0;

endpackage

// File: rtl/unidade_controle_if.sv
// Instruction-fetch bus between the control unit (master) and instruction memory (slave).
interface unidade_controle_if #(
  parameter int bits_palavra = 16,
  parameter int largura_pc   = 8
) ();
  logic                    imem_req;
  logic [largura_pc-1:0]   imem_addr;
  logic                    imem_ack;
  logic [bits_palavra-1:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/unidade_controle_avalia_condicao.sv
// Conditional-jump evaluator: picks one flag by index and compares it with the
// required polarity.
module avalia_condicao
  import unidade_controle_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [1:0] indice,
  input  logic       polaridade,
  output logic       tomado
);

  logic flag_sel;

  always_comb begin
    flag_sel = flags[FLAG_BIT_Z];
    case (indice)
      IDX_Z:   flag_sel = flags[FLAG_BIT_Z];
      IDX_C:   flag_sel = flags[FLAG_BIT_C];
      IDX_S:   flag_sel = flags[FLAG_BIT_S];
      IDX_O:   flag_sel = flags[FLAG_BIT_O];
      default: flag_sel = flags[FLAG_BIT_Z];
    endcase
    tomado = (flag_sel == polaridade);
  end

endmodule

// File: rtl/unidade_controle.sv
// Control unit: fetches instructions over the imem bus, decodes them and
// drives the datapath (register selects, ALU op, execute strobe, clears).
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 4,
  parameter int largura_pc    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  unidade_controle_if.master       imem,
  output logic                     Hab_Escrita,
  output logic [end_registros-1:0] Sel_SA,
  output logic [end_registros-1:0] Sel_SB,
  output logic [4:0]               controleOperacao,
  output logic                     en,
  output logic                     reset_Ban_Registros,
  output logic                     reset_Flags,
  input  logic [3:0]               Flags_ZCSO,
  output logic [largura_pc-1:0]    pc,
  output logic                     halted
);

  estado_t                 estado;
  logic [bits_palavra-1:0] ir;
  logic                    req_q;
  logic                    limpa_q;
  classe_t                 classe;
  logic                    cond_ok;
  logic                    salto_tomado;
  logic [largura_pc-1:0]   alvo;
  logic [largura_pc-1:0]   pc_mais_um;

  assign classe       = classe_t'(ir[CLASSE_MSB:CLASSE_LSB]);
  assign alvo         = largura_pc'(ir[JMP_ALVO_MSB:JMP_ALVO_LSB]);
  assign pc_mais_um   = pc + largura_pc'(1);
  assign salto_tomado = (classe == CL_JINC) || cond_ok;

  avalia_condicao u_avalia_condicao (
    .flags      (Flags_ZCSO),
    .indice     (ir[JMP_IDX_MSB:JMP_IDX_LSB]),
    .polaridade (ir[JMP_POL_BIT]),
    .tomado     (cond_ok)
  );

  assign imem.imem_req       = req_q;
  assign imem.imem_addr      = pc;
  assign reset_Ban_Registros = limpa_q;
  assign reset_Flags         = limpa_q;

  // All outputs are registered: each transition loads the values of the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado           <= S_INIT;
      pc               <= '0;
      ir               <= '0;
      req_q            <= 1'b0;
      en               <= 1'b0;
      Hab_Escrita      <= 1'b0;
      Sel_SA           <= '0;
      Sel_SB           <= '0;
      controleOperacao <= '0;
      halted           <= 1'b0;
      limpa_q          <= 1'b1;
    end else begin
      case (estado)
        S_INIT: begin
          limpa_q <= 1'b0;
          estado  <= S_IDLE;
        end

        S_IDLE: begin
          pc <= '0;
          if (start) begin
            req_q  <= 1'b1;
            estado <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (imem.imem_ack) begin
            ir     <= imem.imem_data;
            req_q  <= 1'b0;
            estado <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (classe)
            CL_ALU: begin
              en               <= 1'b1;
              Hab_Escrita      <= ir[ALU_HAB_BIT];
              Sel_SA           <= end_registros'(ir[ALU_SA_MSB:ALU_SA_LSB]);
              Sel_SB           <= end_registros'(ir[ALU_SB_MSB:ALU_SB_LSB]);
              controleOperacao <= ir[ALU_OP_MSB:ALU_OP_LSB];
              estado           <= S_EXEC;
            end
            CL_JCOND, CL_JINC: begin
              pc     <= salto_tomado ? alvo : pc_mais_um;
              req_q  <= 1'b1;
              estado <= S_FETCH;
            end
            default: begin
              halted <= 1'b1;
              estado <= S_HALT;
            end
          endcase
        end

        S_EXEC: begin
          en               <= 1'b0;
          Hab_Escrita      <= 1'b0;
          Sel_SA           <= '0;
          Sel_SB           <= '0;
          controleOperacao <= '0;
          pc               <= pc_mais_um;
          req_q            <= 1'b1;
          estado           <= S_FETCH;
        end

        // Only reset leaves HALT
        S_HALT: begin
          estado <= S_HALT;
        end

        default: estado <= S_INIT;
      endcase
    end
  end

endmodule
